// File: rtl/div32_seq_if.sv
// div32_seq_if: start/done handshake and result bus of the sequential divider
interface div32_seq_if;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_zero;
   modport master (output start, dividend, divisor,
                   input  busy, done, quotient, remainder, div_zero);
   modport slave  (input  start, dividend, divisor,
                   output busy, done, quotient, remainder, div_zero);
endinterface

// File: rtl/div32_seq.sv
// div32_seq: unsigned 32-bit restoring divider, one quotient bit per clock,
// operands latched at start, results held until the next completed operation
module div32_seq (
   input  logic       clk,
   input  logic       rst_n,
   div32_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   state_e      state_q;
   logic [31:0] q_sh_q, rem_q, d_q, quot_q, remd_q;
   logic [5:0]  cnt_q;
   logic        busy_q, done_q, dz_q;
   logic [32:0] shifted;
   logic [33:0] diff;
   logic        borrow;
   logic [31:0] rem_d, q_sh_d;
   always_comb begin
      shifted = {rem_q, q_sh_q[31]};
      diff    = {1'b0, shifted} - {2'b00, d_q};
      // rem < d keeps diff[32] clear unless the trial subtraction borrowed
      borrow  = diff[33] | diff[32];
      rem_d   = borrow ? shifted[31:0] : diff[31:0];
      q_sh_d  = {q_sh_q[30:0], ~borrow};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         q_sh_q  <= '0;
         rem_q   <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         remd_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.start) begin
               busy_q <= 1'b1;
               if (bus.divisor == '0) begin
                  quot_q  <= '1;
                  remd_q  <= bus.dividend;
                  dz_q    <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  rem_q   <= '0;
                  q_sh_q  <= bus.dividend;
                  d_q     <= bus.divisor;
                  cnt_q   <= '0;
                  dz_q    <= 1'b0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               rem_q  <= rem_d;
               q_sh_q <= q_sh_d;
               cnt_q  <= cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  quot_q  <= q_sh_d;
                  remd_q  <= rem_d;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.quotient  = quot_q;
   assign bus.remainder = remd_q;
   assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: directed and random checks of div32_seq results, latency and handshake
module tb_div32_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   div32_seq_if bus();
   div32_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Launch one operation from IDLE and check latency, results and release
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input string tag);
      int lat;
      @(negedge clk);
      bus.start = 1'b1;
      bus.dividend = a;
      bus.divisor = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.dividend = $urandom;
      bus.divisor = $urandom;
      chk({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
      if (b != 0) chk({tag, "_dz_e0"}, 32'(bus.div_zero), 32'd0);
      lat = 0;
      while (!bus.done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), (b == 0) ? 32'd0 : 32'd32);
      chk({tag, "_q"}, bus.quotient, eq);
      chk({tag, "_r"}, bus.remainder, er);
      chk({tag, "_dz"}, 32'(bus.div_zero), 32'(edz));
      @(posedge clk);
      #1;
      chk({tag, "_done_off"}, 32'(bus.done), 32'd0);
      chk({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
      chk({tag, "_q_hold"}, bus.quotient, eq);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      logic [31:0] a, b, eq, er;
      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      #12;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_q", bus.quotient, 32'd0);
      chk("rst_r", bus.remainder, 32'd0);
      chk("rst_dz", 32'(bus.div_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "d100_7");
      run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, "max_1");
      run_op(32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, "max_big");
      run_op(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, "d3_10");
      run_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, "d5_0");
      run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, "d9_3");

      // 1000 / 33 with noisy inputs during RUN and a start held through DONE
      @(negedge clk);
      bus.start = 1'b1;
      bus.dividend = 32'd1000;
      bus.divisor = 32'd33;
      @(posedge clk);
      #1;
      pulses = 0;
      for (int i = 1; i <= 33; i++) begin
         bus.start = (i == 33 || bus.done) ? 1'b1 : 1'($urandom);
         bus.dividend = $urandom;
         bus.divisor = $urandom_range(0, 3);
         @(posedge clk);
         #1;
         if (bus.done) begin
            pulses++;
            chk("noisy_q", bus.quotient, 32'd30);
            chk("noisy_r", bus.remainder, 32'd10);
         end
      end
      bus.start = 1'b0;
      chk("noisy_pulses", 32'(pulses), 32'd1);
      chk("noisy_busy_after", 32'(bus.busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) pulses++;
      end
      chk("noisy_no_relaunch", 32'(pulses), 32'd1);

      // Reset asserted at E10 of 1000 / 33 aborts the operation
      @(negedge clk);
      bus.start = 1'b1;
      bus.dividend = 32'd1000;
      bus.divisor = 32'd33;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_q", bus.quotient, 32'd0);
      chk("abort_r", bus.remainder, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) pulses++;
      end
      chk("abort_no_done", 32'(pulses), 32'd0);
      run_op(32'd50, 32'd7, 32'd7, 32'd1, 1'b0, "d50_7");

      for (int i = 0; i < 500; i++) begin
         a = $urandom;
         case (i % 5)
            0: b = 32'd0;
            1: begin a = a >> 4; b = a + 32'd1 + ($urandom >> 8); end
            2: b = 32'd1 << $urandom_range(0, 31);
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         eq = (b == 0) ? 32'hFFFF_FFFF : a / b;
         er = (b == 0) ? a : a % b;
         run_op(a, b, eq, er, b == 0, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
